// File: rtl/button_pkg.sv
// Shared types for the button front end and the menu control logic.
package button_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } btn_state_t;

    localparam int CNT_W = 16;
endpackage

// File: rtl/btn_sync2.sv
// Two-flop synchroniser for asynchronous active-low inputs; resets to released (1).
module btn_sync2 (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);
    logic s1_q, s2_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;
endmodule

// File: rtl/button_event_fsm.sv
// Converts a debounced active-low button level into press/release/long-press strobes.
// Auto-repeat strobes are generated only when BUTTON_REPEAT_EN is defined.
module button_event_fsm
    import button_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = 1000,
    parameter int unsigned REPEAT_CYCLES = 250
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic btn_n_i,
    output logic press_o,
    output logic release_o,
    output logic long_press_o,
    output logic repeat_o,
    output logic held_o
);
    localparam bit PARAMS_OK = (HOLD_CYCLES >= 2) && (HOLD_CYCLES <= 65535) &&
                               (REPEAT_CYCLES >= 2) && (REPEAT_CYCLES <= 65535);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    if (!PARAMS_OK) begin : g_bad_params
        $error("button_event_fsm: HOLD_CYCLES/REPEAT_CYCLES outside 2..65535");
    end

    logic             s2;
    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic             held_q, held_d;

    btn_sync2 u_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (btn_n_i),
        .q_o     (s2)
    );

`ifdef BUTTON_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    logic repeat_q, repeat_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
`ifdef BUTTON_REPEAT_EN
        repeat_d  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (!s2) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            PRESSED: begin
                // Release wins over a coincident hold expiry.
                if (s2) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = LONG;
                    long_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LONG: begin
                if (s2) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else begin
`ifdef BUTTON_REPEAT_EN
                    if (cnt_q == REPEAT_LAST) begin
                        repeat_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`else
                    cnt_d = '0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        held_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            held_q    <= held_d;
        end
    end

`ifdef BUTTON_REPEAT_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) repeat_q <= 1'b0;
        else         repeat_q <= repeat_d;
    end
    assign repeat_o = repeat_q;
`else
    assign repeat_o = 1'b0;
`endif

    assign press_o      = press_q;
    assign release_o    = release_q;
    assign long_press_o = long_q;
    assign held_o       = held_q;
endmodule
